// File: rtl/serial2mem.sv
// rtl/serial2mem.sv - packs six UART bytes MSB-first into 48-bit FIFO words.
// State advances on the falling clock edge to line up with the FIFO write port.
module serial2mem #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    input  logic        write_full,
    output logic        write_clock_enable,
    output logic [47:0] write_data,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam logic S_COLLECT = 1'b0;
    localparam logic S_WRITE   = 1'b1;

    // Gap value seen on the edge that completes TIMEOUT-1 idle clocks.
    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT - 2);

    logic        r_state;
    logic [47:0] r_asm;
    logic [2:0]  r_byte_cnt;
    logic [15:0] r_gap;
    logic        r_wce;
    logic [47:0] r_write_data;
    logic        r_overflow;
    logic [7:0]  r_drop_count;

    logic [7:0]  w_drop_next;
    logic [47:0] w_asm_shift;

    assign w_drop_next = (r_drop_count == 8'hFF) ? 8'hFF : r_drop_count + 8'd1;
    assign w_asm_shift = {r_asm[39:0], uart_data};

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_COLLECT;
            r_asm        <= '0;
            r_byte_cnt   <= '0;
            r_gap        <= '0;
            r_wce        <= 1'b0;
            r_write_data <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wce <= 1'b0;
            if (r_state == S_COLLECT) begin
                if (uart_valid) begin
                    r_asm <= w_asm_shift;
                    r_gap <= '0;
                    if (r_byte_cnt == 3'd5) begin
                        r_byte_cnt <= '0;
                        r_state    <= S_WRITE;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end else if (r_byte_cnt != 3'd0) begin
                    if (r_gap == GAP_LAST) begin
                        r_byte_cnt   <= '0;
                        r_gap        <= '0;
                        r_drop_count <= w_drop_next;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
            end else begin
                if (!write_full) begin
                    r_write_data <= r_asm;
                    r_wce        <= 1'b1;
                    r_state      <= S_COLLECT;
                    // A byte on the release edge starts the next word.
                    if (uart_valid) begin
                        r_asm      <= w_asm_shift;
                        r_byte_cnt <= 3'd1;
                        r_gap      <= '0;
                    end
                end else if (uart_valid) begin
                    r_overflow   <= 1'b1;
                    r_drop_count <= w_drop_next;
                end
            end
        end
    end

    assign write_clock_enable = r_wce;
    assign write_data         = r_write_data;
    assign overflow           = r_overflow;
    assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_serial2mem.sv
// tb/tb_serial2mem.sv - self-checking bench for serial2mem with a byte-queue reference model.
module tb_serial2mem;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        write_full = 1'b0;
    logic        write_clock_enable;
    logic [47:0] write_data;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] got[$];

    // Reference model state
    logic [7:0]  m_pend[$];
    int          m_idle = 0;
    bit          m_have = 1'b0;
    logic [47:0] m_word = '0;
    logic        m_wce = 1'b0;
    logic [47:0] m_wdata = '0;
    logic        m_ovf = 1'b0;
    int          m_drops = 0;

    serial2mem #(.TIMEOUT(TO)) dut (
        .clock              (clock),
        .reset              (reset),
        .uart_valid         (uart_valid),
        .uart_data          (uart_data),
        .write_full         (write_full),
        .write_clock_enable (write_clock_enable),
        .write_data         (write_data),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Model: bytes queue up into a word; a complete word waits for a non-full FIFO.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_pend.delete();
                m_idle = 0; m_have = 1'b0; m_word = '0;
                m_wce = 1'b0; m_wdata = '0; m_ovf = 1'b0; m_drops = 0;
            end else begin
                m_wce = 1'b0;
                if (m_have) begin
                    if (!write_full) begin
                        m_wdata = m_word;
                        m_wce   = 1'b1;
                        m_have  = 1'b0;
                        if (uart_valid) begin
                            m_pend.push_back(uart_data);
                            m_idle = 0;
                        end
                    end else if (uart_valid) begin
                        m_ovf   = 1'b1;
                        m_drops = sat_inc(m_drops);
                    end
                end else if (uart_valid) begin
                    m_pend.push_back(uart_data);
                    m_idle = 0;
                    if (m_pend.size() == 6) begin
                        m_word = '0;
                        foreach (m_pend[k]) m_word = (m_word << 8) | 48'(m_pend[k]);
                        m_have = 1'b1;
                        m_pend.delete();
                    end
                end else if (m_pend.size() > 0) begin
                    m_idle++;
                    if (m_idle == TO - 1) begin
                        m_pend.delete();
                        m_idle  = 0;
                        m_drops = sat_inc(m_drops);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison on the rising edge, half a cycle after the update edge.
    initial begin
        @(negedge clock);
        forever begin
            @(posedge clock);
            check("wce",   64'(write_clock_enable), 64'(m_wce));
            check("wdata", 64'(write_data),         64'(m_wdata));
            check("ovf",   64'(overflow),           64'(m_ovf));
            check("drops", 64'(drop_count),         64'(m_drops));
            if (write_clock_enable) got.push_back(write_data);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_valid = 1'b1;
        uart_data  = b;
        @(posedge clock);
        #1;
        uart_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        idle(3);
        check("rst_wce",   64'(write_clock_enable), 64'd0);
        check("rst_wdata", 64'(write_data),         64'd0);
        check("rst_ovf",   64'(overflow),           64'd0);
        check("rst_drops", 64'(drop_count),         64'd0);
        reset = 1'b1;
        idle(2);

        // Back-to-back bytes: strobe one clock after the sixth byte
        got.delete();
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        check("b2b_wce_wait", 64'(write_clock_enable), 64'd0);
        idle(1);
        check("b2b_wce",   64'(write_clock_enable), 64'd1);
        check("b2b_wdata", 64'(write_data),         64'h010203040506);
        idle(1);
        check("b2b_wce_end", 64'(write_clock_enable), 64'd0);
        check("b2b_wdata_hold", 64'(write_data),    64'h010203040506);
        idle(2);
        check("b2b_count", 64'(got.size()), 64'd1);

        // Spaced bytes: two words in order
        got.delete();
        for (int i = 1; i <= 12; i++) begin
            send_byte(8'(i));
            idle(2);
        end
        idle(3);
        check("spaced_count", 64'(got.size()), 64'd2);
        check("spaced_w0",    64'(got[0]), 64'h010203040506);
        check("spaced_w1",    64'(got[1]), 64'h0708090A0B0C);
        check("spaced_drops", 64'(drop_count), 64'd0);

        // Timeout resynchronisation
        do_reset();
        got.delete();
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(10);
        check("to_drops_mid", 64'(drop_count), 64'd1);
        for (int i = 8'h11; i <= 8'h16; i++) send_byte(8'(i));
        idle(3);
        check("to_count", 64'(got.size()), 64'd1);
        check("to_w0",    64'(got[0]), 64'h111213141516);
        check("to_drops", 64'(drop_count), 64'd1);
        check("to_ovf",   64'(overflow), 64'd0);

        // Back-pressure: hold word, drop bytes, byte on release edge starts next word
        do_reset();
        got.delete();
        write_full = 1'b1;
        for (int i = 8'h21; i <= 8'h26; i++) send_byte(8'(i));
        idle(2);
        send_byte(8'h31);
        send_byte(8'h32);
        idle(2);
        check("bp_nowrite", 64'(got.size()), 64'd0);
        check("bp_ovf",     64'(overflow),   64'd1);
        check("bp_drops",   64'(drop_count), 64'd2);
        write_full = 1'b0;
        send_byte(8'h41);
        for (int i = 8'h42; i <= 8'h46; i++) send_byte(8'(i));
        idle(3);
        check("bp_count", 64'(got.size()), 64'd2);
        check("bp_w0",    64'(got[0]), 64'h212223242526);
        check("bp_w1",    64'(got[1]), 64'h414243444546);
        check("bp_drops_after", 64'(drop_count), 64'd2);

        // Reset mid-word, then drop-count saturation
        do_reset();
        got.delete();
        send_byte(8'h51);
        send_byte(8'h52);
        send_byte(8'h53);
        do_reset();
        for (int i = 8'h61; i <= 8'h66; i++) send_byte(8'(i));
        idle(3);
        check("rw_count", 64'(got.size()), 64'd1);
        check("rw_w0",    64'(got[0]), 64'h616263646566);
        check("rw_drops", 64'(drop_count), 64'd0);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i));
            idle(TO);
        end
        check("sat_drops", 64'(drop_count), 64'd255);
        check("sat_nowrite", 64'(got.size()), 64'd1);
        check("sat_ovf",   64'(overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial2mem.md
# serial2mem

Receive-side counterpart of the capture-to-UART path. Takes single-byte strobes from the UART receiver and packs every 6 consecutive bytes, MSB first, into one 48-bit word. Writes each complete word into the 48-bit write port of the replay/command FIFO. Handles inter-byte timeouts (resynchronisation) and FIFO back-pressure (drop and count).

## Interface
- `TIMEOUT`, default 1000 — idle clocks between bytes of a partial word before that partial word is discarded; legal range 2..65535.
- `clock`  in  1  — system clock. All state updates happen on the falling edge, matching the FIFO port timing.
- `reset`  in  1  — reset, asynchronous, active-low.
- `uart_valid`  in  1  — one-cycle strobe: `uart_data` holds a received byte.
- `uart_data`  in  8  — received byte; sampled only when `uart_valid` is 1.
- `write_full`  in  1  — FIFO full; high means no write may be issued.
- `write_clock_enable`  out  1  — one-cycle FIFO write strobe.
- `write_data`  out  48  — word presented to the FIFO.
- `overflow`  out  1  — sticky; set when a byte is dropped because the FIFO was full.
- `drop_count`  out  8  — saturating count of dropped bytes plus discarded partial words.

## Operation
- Internal state:
  - 48-bit shift register `asm`.
  - 3-bit `byte_cnt`, range 0..5.
  - 16-bit gap counter `gap`.
  - FSM with states `COLLECT` and `WRITE`.
- Reset values:
  - Outputs: `write_clock_enable`=0, `write_data`=0, `overflow`=0, `drop_count`=0.
  - Internal: `asm`=0, `byte_cnt`=0, `gap`=0, state `COLLECT`.
- Reset may be asserted mid-word or while in `WRITE`. The pending word and any partial word are lost and no write is issued.
- `COLLECT` state:
  - On `uart_valid`: `asm` <= {`asm`[39:0], `uart_data`}, `gap` <= 0.
  - If `byte_cnt`==5: `byte_cnt` <= 0 and go to `WRITE`. Otherwise `byte_cnt`++.
  - Byte order: the first byte of a word ends in `write_data`[47:40]; the sixth ends in [7:0].
  - With no `uart_valid` and `byte_cnt`>0: `gap`++.
  - When `gap` reaches `TIMEOUT`-1 with no `uart_valid` on that edge:
    - `byte_cnt` <= 0 and `gap` <= 0.
    - `drop_count` increments once, saturating at 255.
    - `overflow` is unchanged.
  - With `byte_cnt`==0: `gap` holds at 0.
- `WRITE` state:
  - If ~`write_full`:
    - `write_data` <= `asm`, `write_clock_enable` <= 1, return to `COLLECT`.
    - If `uart_valid` arrives on the same edge, that byte is accepted as byte 0 of the next word: `byte_cnt` <= 1 and `asm` shifts. The word already latched into `write_data` is unaffected.
  - If `write_full`:
    - Stay in `WRITE` holding `asm`; no write is issued.
    - Any `uart_valid` here drops the byte: `overflow` <= 1, `drop_count`++ (saturating), `asm` unchanged.
- `write_clock_enable` is 1 for exactly one clock per word, then returns to 0.
- `write_data` is held stable until the next word is written.
- `overflow` and `drop_count` clear only on reset.

## Timing
- `uart_valid` is sampled at a falling edge E.
- 6th byte accepted at edge E: `WRITE` is entered at E.
  - With `write_full`=0 at E+1: `write_clock_enable`=1 and `write_data` is valid after E+1; `write_clock_enable` is 0 after E+2.
  - Completion-to-strobe latency is 1 clock when the FIFO is not full.
- If `write_full` is 1, the strobe is delayed to the first edge where it is 0.
- Byte timeout: last byte at E, no further `uart_valid` → partial word discarded at edge E+`TIMEOUT`-1.
- Minimum legal `uart_valid` spacing is 1 clock (back-to-back strobes). Each strobe is handled by the rules above.

## Test plan
- Reset check: drive `reset`=0 → all outputs are 0.
- Back-to-back `uart_valid` with bytes 01 02 03 04 05 06, `write_full`=0 → one `write_clock_enable` pulse, `write_data`=48'h010203040506, strobe exactly 1 clock after the 6th byte.
- 12 bytes with one strobe every 3 clocks → two writes, in order: 48'h010203040506, then 48'h0708090A0B0C. `drop_count`=0 throughout.
- `TIMEOUT`=8. Send AA BB, wait 10 clocks, then send 11..16 → first write is 48'h111213141516, `drop_count`=1, `overflow`=0.
- Complete a word with `write_full`=1, send 2 more bytes, then release `write_full`:
  - The held word is written after release.
  - `overflow`=1 and `drop_count`=2.
  - A byte arriving on the release edge becomes byte 0 of the next word.
- Assert `reset` after 3 bytes, release it, send 6 bytes → only the 6-byte word is written. 300 timeouts → `drop_count` saturates at 255.
